// File: rtl/queue_fifo.sv
// queue_fifo: parametrised single-clock FIFO with first-word-fall-through
// output, true full flag, occupancy count, programmable almost-full
// threshold and sticky overflow/underflow error flags.
//
// Handshake semantics (one place, read this first):
//   - A write is accepted when wr_en is high and the queue is not full, or
//     when it is full but a pop (rd_en) happens in the same cycle.
//   - A read is accepted when rd_en is high and the queue is not empty. A read
//     while empty is dropped even if a write lands in the same cycle; the
//     written word stays queued and becomes the new head.
//   - dout always shows the head word (asynchronous RAM read); it carries no
//     meaning while empty is high.
//   - Status outputs come from the registered pointers only, so there is no
//     combinational path from wr_en/rd_en to any output.
module queue_fifo #(
  parameter int WIDTH        = 32,
  parameter int DEPTH_LOG2   = 6,
  parameter int AFULL_THRESH = (1 << DEPTH_LOG2) - 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Threshold expressed at the count width so the compare is width-matched.
  localparam logic [DEPTH_LOG2:0] AF_THRESH = AFULL_THRESH[DEPTH_LOG2:0];

  // Storage: plain register array with asynchronous read (maps to LUT RAM).
  logic [WIDTH-1:0]      r_mem [DEPTH];

  // Pointers carry one extra wrap bit to distinguish full from empty.
  logic [DEPTH_LOG2:0]   r_ra;
  logic [DEPTH_LOG2:0]   r_wa;

  logic                  r_overflow;
  logic                  r_underflow;

  logic [DEPTH_LOG2-1:0] w_ra_addr;
  logic [DEPTH_LOG2-1:0] w_wa_addr;
  logic                  w_empty;
  logic                  w_full;
  logic [DEPTH_LOG2:0]   w_count;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ovf_evt;
  logic                  w_unf_evt;

  // Status decode from the registered pointers only.
  always_comb begin
    w_ra_addr = r_ra[DEPTH_LOG2-1:0];
    w_wa_addr = r_wa[DEPTH_LOG2-1:0];
    w_empty   = (r_ra == r_wa);
    w_full    = (w_ra_addr == w_wa_addr) && (r_ra[DEPTH_LOG2] != r_wa[DEPTH_LOG2]);
    // Modular subtraction handles pointer wrap without special cases.
    w_count   = r_wa - r_ra;
  end

  // Acceptance and error-event decode for this cycle's requests.
  always_comb begin
    // A simultaneous pop frees the slot this write needs, so full is no block.
    w_wr_acc  = wr_en && (!w_full || rd_en);
    w_rd_acc  = rd_en && !w_empty;
    w_ovf_evt = wr_en && w_full && !rd_en;
    w_unf_evt = rd_en && w_empty;
  end

  // Write port of the storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[w_wa_addr] <= din;
    end
  end

  // Write pointer: advances on each accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wa <= '0;
    end else if (w_wr_acc) begin
      r_wa <= r_wa + 1'b1;
    end
  end

  // Read pointer: advances on each accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra <= '0;
    end else if (w_rd_acc) begin
      r_ra <= r_ra + 1'b1;
    end
  end

  // Sticky error flags: set on the offending request, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt) r_overflow  <= 1'b1;
      if (w_unf_evt) r_underflow <= 1'b1;
    end
  end

  // Output mapping; head word is read straight from the array (FWFT).
  always_comb begin
    dout        = r_mem[w_ra_addr];
    empty       = w_empty;
    full        = w_full;
    count       = w_count;
    almost_full = (w_count >= AF_THRESH);
    overflow    = r_overflow;
    underflow   = r_underflow;
  end

endmodule

// File: tb/tb_queue_fifo.sv
// tb_queue_fifo: directed table-driven checks plus hand-written corner-case
// sequences for queue_fifo, using a depth-4 and a depth-8 instance.
module tb_queue_fifo;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: depth 4, almost-full at 3 ----------------
  logic [31:0] a_din;
  logic        a_wr;
  logic        a_rd;
  logic [31:0] a_dout;
  logic        a_empty;
  logic        a_full;
  logic        a_af;
  logic [2:0]  a_count;
  logic        a_ovf;
  logic        a_unf;

  queue_fifo #(.WIDTH(32), .DEPTH_LOG2(2), .AFULL_THRESH(3)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .din         (a_din),
    .wr_en       (a_wr),
    .rd_en       (a_rd),
    .dout        (a_dout),
    .empty       (a_empty),
    .full        (a_full),
    .almost_full (a_af),
    .count       (a_count),
    .overflow    (a_ovf),
    .underflow   (a_unf)
  );

  // ---------------- DUT B: depth 8, almost-full at 6 ----------------
  logic [31:0] b_din;
  logic        b_wr;
  logic        b_rd;
  logic [31:0] b_dout;
  logic        b_empty;
  logic        b_full;
  logic        b_af;
  logic [3:0]  b_count;
  logic        b_ovf;
  logic        b_unf;

  queue_fifo #(.WIDTH(32), .DEPTH_LOG2(3), .AFULL_THRESH(6)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .din         (b_din),
    .wr_en       (b_wr),
    .rd_en       (b_rd),
    .dout        (b_dout),
    .empty       (b_empty),
    .full        (b_full),
    .almost_full (b_af),
    .count       (b_count),
    .overflow    (b_ovf),
    .underflow   (b_unf)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic        e;
    logic        f;
    logic        af;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
    logic        dchk;
    logic [31:0] d;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] din,
                              input logic e, input logic f, input logic af,
                              input logic [2:0] cnt, input logic ovf, input logic unf,
                              input logic dchk, input logic [31:0] d);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din;
    v.e = e; v.f = f; v.af = af; v.cnt = cnt;
    v.ovf = ovf; v.unf = unf; v.dchk = dchk; v.d = d;
    return v;
  endfunction

  // ---------------- driver / checker tasks ----------------
  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
    b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
  endtask

  task automatic chk_a_status(input string tag, input logic e, input logic f, input logic af,
                              input logic [2:0] cnt, input logic ovf, input logic unf);
    chk({tag, " a_empty"},       32'(a_empty), 32'(e));
    chk({tag, " a_full"},        32'(a_full),  32'(f));
    chk({tag, " a_almost_full"}, 32'(a_af),    32'(af));
    chk({tag, " a_count"},       32'(a_count), 32'(cnt));
    chk({tag, " a_overflow"},    32'(a_ovf),   32'(ovf));
    chk({tag, " a_underflow"},   32'(a_unf),   32'(unf));
  endtask

  // ---------------- main test ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();

    // Directed table for DUT A: fill/drain, overflow, push-while-full-with-pop,
    // underflow with a simultaneous write.
    vecs[0]  = mk(1,0,32'h11, 0,0,0,3'd1, 0,0, 1,32'h11);
    vecs[1]  = mk(1,0,32'h22, 0,0,0,3'd2, 0,0, 1,32'h11);
    vecs[2]  = mk(1,0,32'h33, 0,0,1,3'd3, 0,0, 1,32'h11);
    vecs[3]  = mk(1,0,32'h44, 0,1,1,3'd4, 0,0, 1,32'h11);
    vecs[4]  = mk(0,1,32'h00, 0,0,1,3'd3, 0,0, 1,32'h22);
    vecs[5]  = mk(0,1,32'h00, 0,0,0,3'd2, 0,0, 1,32'h33);
    vecs[6]  = mk(0,1,32'h00, 0,0,0,3'd1, 0,0, 1,32'h44);
    vecs[7]  = mk(0,1,32'h00, 1,0,0,3'd0, 0,0, 0,32'h00);
    vecs[8]  = mk(1,0,32'h66, 0,0,0,3'd1, 0,0, 1,32'h66);
    vecs[9]  = mk(1,0,32'h77, 0,0,0,3'd2, 0,0, 1,32'h66);
    vecs[10] = mk(1,0,32'h88, 0,0,1,3'd3, 0,0, 1,32'h66);
    vecs[11] = mk(1,0,32'h99, 0,1,1,3'd4, 0,0, 1,32'h66);
    vecs[12] = mk(1,0,32'h55, 0,1,1,3'd4, 1,0, 1,32'h66);
    vecs[13] = mk(1,1,32'h55, 0,1,1,3'd4, 1,0, 1,32'h77);
    vecs[14] = mk(0,1,32'h00, 0,0,1,3'd3, 1,0, 1,32'h88);
    vecs[15] = mk(0,1,32'h00, 0,0,0,3'd2, 1,0, 1,32'h99);
    vecs[16] = mk(0,1,32'h00, 0,0,0,3'd1, 1,0, 1,32'h55);
    vecs[17] = mk(0,1,32'h00, 1,0,0,3'd0, 1,0, 0,32'h00);
    vecs[18] = mk(1,1,32'hAA, 0,0,0,3'd1, 1,1, 1,32'hAA);
    vecs[19] = mk(0,1,32'h00, 1,0,0,3'd0, 1,1, 0,32'h00);

    // Reset both instances, with requests asserted to show they are ignored.
    rst = 1'b1;
    a_wr = 1'b1; a_rd = 1'b1; a_din = 32'hDEAD_BEEF;
    b_wr = 1'b1; b_din = 32'hDEAD_BEEF;
    step();
    step();
    rst = 1'b0;
    idle_inputs();
    chk_a_status("reset", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("reset b_empty", 32'(b_empty), 32'd1);
    chk("reset b_count", 32'(b_count), 32'd0);
    chk("reset b_full",  32'(b_full),  32'd0);
    chk("reset b_almost_full", 32'(b_af), 32'd0);
    chk("reset b_flags", {30'd0, b_ovf, b_unf}, 32'd0);

    // DUT B: almost-full rises on the 6th write, falls on the first pop from 6.
    exp_q.delete();
    for (int i = 1; i <= 6; i++) begin
      b_wr = 1'b1; b_din = 32'hB000_0000 + 32'(i);
      step();
      exp_q.push_back(b_din);
      chk($sformatf("b write %0d count", i), 32'(b_count), 32'(i));
      chk($sformatf("b write %0d almost_full", i), 32'(b_af), (i >= 6) ? 32'd1 : 32'd0);
    end
    b_wr = 1'b0; b_rd = 1'b1;
    step();
    void'(exp_q.pop_front());
    b_rd = 1'b0;
    chk("b pop from 6 almost_full", 32'(b_af), 32'd0);
    chk("b pop from 6 count", 32'(b_count), 32'd5);
    chk("b pop from 6 dout", b_dout, exp_q[0]);
    for (int i = 7; i <= 9; i++) begin
      b_wr = 1'b1; b_din = 32'hB000_0000 + 32'(i);
      step();
      exp_q.push_back(b_din);
    end
    b_wr = 1'b0;
    chk("b fill full", 32'(b_full), 32'd1);
    chk("b fill count", 32'(b_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b drain %0d dout", i), b_dout, exp_q[0]);
      b_rd = 1'b1;
      step();
      void'(exp_q.pop_front());
    end
    b_rd = 1'b0;
    chk("b drained empty", 32'(b_empty), 32'd1);
    chk("b no error flags", {30'd0, b_ovf, b_unf}, 32'd0);

    // DUT A: table-driven vectors.
    for (int i = 0; i < NVEC; i++) begin
      a_wr = vecs[i].wr; a_rd = vecs[i].rd; a_din = vecs[i].din;
      step();
      chk_a_status($sformatf("vec %0d", i), vecs[i].e, vecs[i].f, vecs[i].af,
                   vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
      if (vecs[i].dchk) chk($sformatf("vec %0d a_dout", i), a_dout, vecs[i].d);
    end
    idle_inputs();

    // DUT A: random interleaved push/pop against a reference queue model.
    begin
      logic m_ovf;
      logic m_unf;
      logic m_full;
      logic m_empty;
      logic wr_acc;
      logic rd_acc;
      int   wr_total;
      m_ovf = 1'b1; m_unf = 1'b1;  // left set by the table above
      wr_total = 0;
      exp_q.delete();
      for (int c = 0; c < 100; c++) begin
        a_wr  = 1'($urandom_range(0, 1));
        a_rd  = 1'($urandom_range(0, 1));
        a_din = $urandom;
        m_full  = (exp_q.size() == 4);
        m_empty = (exp_q.size() == 0);
        wr_acc  = a_wr && (!m_full || a_rd);
        rd_acc  = a_rd && !m_empty;
        if (a_wr && m_full && !a_rd) m_ovf = 1'b1;
        if (a_rd && m_empty)         m_unf = 1'b1;
        step();
        if (rd_acc) void'(exp_q.pop_front());
        if (wr_acc) begin
          exp_q.push_back(a_din);
          wr_total++;
        end
        chk_a_status($sformatf("rand %0d", c), exp_q.size() == 0, exp_q.size() == 4,
                     exp_q.size() >= 3, 3'(exp_q.size()), m_ovf, m_unf);
        if (exp_q.size() != 0) chk($sformatf("rand %0d a_dout", c), a_dout, exp_q[0]);
      end
      idle_inputs();
      // Pointers wrap every 8 accepted writes; make sure several wraps happened.
      chk("rand pointer wraps", (wr_total >= 16) ? 32'd1 : 32'd0, 32'd1);
    end

    // DUT A: reset mid-operation with count 3 and overflow set.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_wr = 1'b1; a_din = 32'hC0 + 32'(i);
      step();
    end
    a_din = 32'hEE;  // rejected: full with no pop
    step();
    a_wr = 1'b0; a_rd = 1'b1;
    step();
    a_rd = 1'b0;
    chk_a_status("pre-reset", 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
    chk("pre-reset a_dout", a_dout, 32'hC1);
    rst = 1'b1; a_wr = 1'b1; a_rd = 1'b1; a_din = 32'hBAD0_0000;
    step();
    rst = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
    chk_a_status("post-reset", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    a_wr = 1'b1; a_din = 32'h77;
    step();
    a_wr = 1'b0;
    chk("post-reset write a_dout", a_dout, 32'h77);
    chk("post-reset write a_count", 32'(a_count), 32'd1);
    chk("post-reset write a_empty", 32'(a_empty), 32'd0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
